// File: rtl/checker_pkg.sv
// Shared encodings for the post-run memory result checker.
package checker_pkg;

   typedef enum logic [1:0] {
      MODE_ASC  = 2'd0,
      MODE_DESC = 2'd1,
      MODE_FIB  = 2'd2,
      MODE_SUM  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/chk_element_eval.sv
// Combinational verdict for one element read back from memory.
module chk_element_eval
   import checker_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int IDX_W  = 8
) (
   input  mode_e                     mode,
   input  logic [IDX_W-1:0]          idx,
   input  logic signed [DATA_W-1:0]  data,
   input  logic signed [DATA_W-1:0]  prev,
   input  logic signed [DATA_W-1:0]  exp_val,
   output logic                      fail
);

   logic has_prev;

   // Element 0 has no predecessor, so ordering checks start at index 1.
   assign has_prev = (idx != '0);

   always_comb begin
      fail = 1'b0;
      case (mode)
         MODE_ASC:  fail = has_prev && (data < prev);
         MODE_DESC: fail = has_prev && (data > prev);
         MODE_FIB:  fail = (data != exp_val);
         default:   fail = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_result_checker.sv
// Walks a memory region after CPU halt and checks it against a selectable
// property, reporting pass/fail, first failing index and a running sum.
module mem_result_checker
   import checker_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 64,
   parameter int IDX_W      = 8,
   parameter int WORD_BYTES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [IDX_W-1:0]  length,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [DATA_W-1:0] sum
);

   state_e                    state;
   logic                      start_q;
   logic [IDX_W-1:0]          idx;

   mode_e                     mode_q;
   logic [ADDR_W-1:0]         base_q;
   logic [IDX_W-1:0]          len_q;
   logic signed [DATA_W-1:0]  prev_q;
   logic signed [DATA_W-1:0]  exp_prev1;
   logic signed [DATA_W-1:0]  exp_prev2;

   logic signed [DATA_W-1:0]  rd_data_s;
   logic signed [DATA_W-1:0]  exp_cur;
   logic                      start_edge;
   logic                      accept;
   logic                      rd_hit;
   logic                      elem_fail;
   logic                      last_elem;
   logic [IDX_W-1:0]          idx_next;
   logic [ADDR_W-1:0]         next_addr;

   assign rd_data_s  = rd_data;
   assign start_edge = start & ~start_q;
   assign accept     = start_edge && ((state == S_IDLE) || (state == S_DONE));
   assign rd_hit     = (state == S_WAIT) && rd_valid;
   assign idx_next   = idx + IDX_W'(1);
   // idx stays below len_q while reading, so idx_next never wraps.
   assign last_elem  = (idx_next == len_q);
   assign next_addr  = base_q + ADDR_W'(idx_next) * ADDR_W'(WORD_BYTES);
   assign exp_cur    = (idx < IDX_W'(2)) ? DATA_W'(1) : exp_prev1 + exp_prev2;

   chk_element_eval #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_eval (
      .mode    (mode_q),
      .idx     (idx),
      .data    (rd_data_s),
      .prev    (prev_q),
      .exp_val (exp_cur),
      .fail    (elem_fail)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         start_q  <= 1'b0;
         idx      <= '0;
         rd_req   <= 1'b0;
         rd_addr  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail_idx <= '0;
         sum      <= '0;
      end else begin
         start_q <= start;
         rd_req  <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start_edge) begin
                  done     <= 1'b0;
                  pass     <= 1'b0;
                  fail_idx <= '0;
                  sum      <= '0;
                  idx      <= '0;
                  if (length == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state   <= S_REQ;
                     busy    <= 1'b1;
                     rd_req  <= 1'b1;
                     rd_addr <= base_addr;
                  end
               end
            end
            S_REQ: state <= S_WAIT;
            S_WAIT: begin
               if (rd_valid) begin
                  sum <= sum + rd_data;
                  if (elem_fail) begin
                     fail_idx <= idx;
                     pass     <= 1'b0;
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     state    <= S_DONE;
                  end else begin
                     idx <= idx_next;
                     if (last_elem) begin
                        pass  <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                     end else begin
                        state   <= S_REQ;
                        rd_req  <= 1'b1;
                        rd_addr <= next_addr;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Check parameters and history carry no reset; they are loaded on every accepted start.
   always_ff @(posedge clk) begin
      if (accept) begin
         mode_q    <= mode_e'(mode);
         base_q    <= base_addr;
         len_q     <= length;
         exp_prev1 <= '0;
         exp_prev2 <= '0;
      end else if (rd_hit && !elem_fail) begin
         prev_q    <= rd_data_s;
         exp_prev2 <= exp_prev1;
         exp_prev1 <= exp_cur;
      end
   end

endmodule

// File: tb/tb_mem_result_checker.sv
// Randomized bench for mem_result_checker with a loop-based reference model.
module tb_mem_result_checker;

   localparam int DW = 64;
   localparam int AW = 64;
   localparam int IW = 8;
   localparam int WB = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          start;
   logic [1:0]    mode;
   logic [AW-1:0] base_addr;
   logic [IW-1:0] length;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          busy, done, pass;
   logic [IW-1:0] fail_idx;
   logic [DW-1:0] sum;

   logic          start8;
   logic [1:0]    mode8;
   logic [15:0]   base8;
   logic [3:0]    length8;
   logic          rd_req8;
   logic [15:0]   rd_addr8;
   logic          rd_valid8;
   logic [7:0]    rd_data8;
   logic          busy8, done8, pass8;
   logic [3:0]    fail_idx8;
   logic [7:0]    sum8;

   mem_result_checker #(.DATA_W(DW), .ADDR_W(AW), .IDX_W(IW), .WORD_BYTES(WB)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
      .length(length), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
      .rd_data(rd_data), .busy(busy), .done(done), .pass(pass),
      .fail_idx(fail_idx), .sum(sum));

   mem_result_checker #(.DATA_W(8), .ADDR_W(16), .IDX_W(4), .WORD_BYTES(1)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .mode(mode8), .base_addr(base8),
      .length(length8), .rd_req(rd_req8), .rd_addr(rd_addr8), .rd_valid(rd_valid8),
      .rd_data(rd_data8), .busy(busy8), .done(done8), .pass(pass8),
      .fail_idx(fail_idx8), .sum(sum8));

   logic [DW-1:0] mem [256];
   logic [7:0]    mem8 [16];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  req_cnt  = 0;
   bit  rand_lat = 1'b0;

   // Memory responder: answers each rd_req after 1 (or 1..5 random) cycles.
   bit pend;
   int cnt, pidx;
   always @(negedge clk) begin
      rd_valid = 1'b0;
      if (!rst) pend = 1'b0;
      else begin
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               rd_valid = 1'b1;
               rd_data  = mem[pidx];
               pend     = 1'b0;
            end
         end
         if (rd_req === 1'b1) begin
            pend = 1'b1;
            pidx = int'(((rd_addr - base_addr) >> 3) & 64'hFF);
            cnt  = rand_lat ? int'($urandom_range(1, 5)) : 1;
            req_cnt++;
         end
      end
   end

   bit pend8;
   int pidx8;
   always @(negedge clk) begin
      rd_valid8 = 1'b0;
      if (!rst) pend8 = 1'b0;
      else begin
         if (pend8) begin
            rd_valid8 = 1'b1;
            rd_data8  = mem8[pidx8];
            pend8     = 1'b0;
         end
         if (rd_req8 === 1'b1) begin
            pend8 = 1'b1;
            pidx8 = int'(rd_addr8 - base8) & 15;
         end
      end
   end

   // Reference: walk the region with the property rules, stop at first bad element.
   function automatic void model(input int md, input int len, output bit ps,
                                 output int fi, output logic [63:0] sm, output int nread);
      logic [63:0] fib [256];
      bit bad;
      fib[0] = 64'd1;
      fib[1] = 64'd1;
      for (int k = 2; k < 256; k++) fib[k] = fib[k-1] + fib[k-2];
      ps = 1'b1; fi = 0; sm = '0; nread = 0;
      for (int i = 0; i < len; i++) begin
         sm = sm + mem[i];
         nread++;
         case (md)
            0: bad = (i > 0) && ($signed(mem[i]) < $signed(mem[i-1]));
            1: bad = (i > 0) && ($signed(mem[i]) > $signed(mem[i-1]));
            2: bad = (mem[i] != fib[i]);
            default: bad = 1'b0;
         endcase
         if (bad) begin
            ps = 1'b0;
            fi = i;
            break;
         end
      end
   endfunction

   task automatic launch(input int md, input int len, input logic [AW-1:0] base);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      mode      = 2'(md);
      length    = IW'(len);
      base_addr = base;
      start     = 1'b1;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = -1;
      @(posedge clk);
      for (int c = 0; c < budget && cyc < 0; c++) begin
         #1;
         if (done === 1'b1) cyc = c;
         else @(posedge clk);
      end
   endtask

   task automatic test_reset();
      int cyc;
      start = 1'b0; mode = 2'd0; base_addr = '0; length = '0;
      start8 = 1'b0; mode8 = 2'd0; base8 = '0; length8 = '0;
      repeat (3) @(negedge clk);
      n_checks++; if ({busy, done, pass, rd_req, fail_idx, sum, rd_addr} !== '0) begin n_fail++; $display("FAIL reset_outputs: busy=%b done=%b pass=%b rd_req=%b fail_idx=%0d sum=%0d expected all 0", busy, done, pass, rd_req, fail_idx, sum); end
      n_checks++; if ({busy8, done8, pass8, rd_req8, fail_idx8, sum8} !== '0) begin n_fail++; $display("FAIL reset_outputs8: busy=%b done=%b sum=%0d expected all 0", busy8, done8, sum8); end
      // start already high when reset releases must still trigger one check
      start = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      wait_done(10, cyc);
      n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL held_start_edge: done after %0d cycles expected 0", cyc); end
      n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL held_start_pass: got %b expected 1", pass); end
   endtask

   task automatic test_ascending();
      int vals [10] = '{-3, 0, 0, 2, 5, 7, 7, 9, 11, 20};
      int cyc, r0;
      rand_lat = 1'b0;
      for (int i = 0; i < 10; i++) mem[i] = longint'(vals[i]);
      r0 = req_cnt;
      launch(0, 10, 64'h1000);
      wait_done(100, cyc);
      n_checks++; if (cyc !== 20) begin n_fail++; $display("FAIL asc_latency: got %0d cycles expected 20", cyc); end
      n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL asc_pass: got %b expected 1", pass); end
      n_checks++; if (fail_idx !== 8'd0) begin n_fail++; $display("FAIL asc_fail_idx: got %0d expected 0", fail_idx); end
      n_checks++; if (sum !== 64'd58) begin n_fail++; $display("FAIL asc_sum: got %0d expected 58", sum); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL asc_busy: got %b expected 0", busy); end
      n_checks++; if (req_cnt - r0 !== 10) begin n_fail++; $display("FAIL asc_reqs: got %0d expected 10", req_cnt - r0); end
   endtask

   task automatic test_descending();
      int vals [5] = '{9, 8, 8, 10, 1};
      int cyc, r0;
      for (int i = 0; i < 5; i++) mem[i] = longint'(vals[i]);
      r0 = req_cnt;
      launch(1, 5, 64'h2000);
      wait_done(100, cyc);
      n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL desc_timeout: done=%b expected 1", done); end
      n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL desc_pass: got %b expected 0", pass); end
      n_checks++; if (fail_idx !== 8'd3) begin n_fail++; $display("FAIL desc_fail_idx: got %0d expected 3", fail_idx); end
      n_checks++; if (sum !== 64'd35) begin n_fail++; $display("FAIL desc_sum: got %0d expected 35", sum); end
      n_checks++; if (req_cnt - r0 !== 4) begin n_fail++; $display("FAIL desc_reqs: got %0d expected 4", req_cnt - r0); end
   endtask

   task automatic test_fibonacci();
      int cyc;
      longint a, b, t;
      rand_lat = 1'b1;
      a = 1; b = 1;
      for (int i = 0; i < 20; i++) begin
         mem[i] = a;
         t = a + b; a = b; b = t;
      end
      launch(2, 20, 64'h0000_0000_8000_0000);
      wait_done(300, cyc);
      n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL fib_timeout: done=%b expected 1", done); end
      n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL fib_pass: got %b expected 1", pass); end
      n_checks++; if (sum !== 64'd17710) begin n_fail++; $display("FAIL fib_sum: got %0d expected 17710", sum); end
      mem[6] = 64'd14;
      launch(2, 20, 64'h0000_0000_8000_0000);
      wait_done(300, cyc);
      n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL fib_bad_pass: got %b expected 0", pass); end
      n_checks++; if (fail_idx !== 8'd6) begin n_fail++; $display("FAIL fib_bad_idx: got %0d expected 6", fail_idx); end
      n_checks++; if (sum !== 64'd34) begin n_fail++; $display("FAIL fib_bad_sum: got %0d expected 34", sum); end
   endtask

   task automatic test_length_zero();
      int cyc, r0;
      r0 = req_cnt;
      launch(0, 0, 64'h3000);
      wait_done(10, cyc);
      n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL len0_latency: got %0d expected 0", cyc); end
      n_checks++; if ({pass, fail_idx, sum} !== {1'b1, 8'd0, 64'd0}) begin n_fail++; $display("FAIL len0_result: pass=%b fail_idx=%0d sum=%0d expected 1/0/0", pass, fail_idx, sum); end
      repeat (3) @(negedge clk);
      n_checks++; if (req_cnt - r0 !== 0) begin n_fail++; $display("FAIL len0_reqs: got %0d expected 0", req_cnt - r0); end
   endtask

   task automatic test_back_to_back();
      int cyc, r0, r1, nr, fi;
      bit ps;
      logic [63:0] sm;
      rand_lat = 1'b0;
      mem[0] = 64'd5;
      for (int i = 1; i < 8; i++) mem[i] = mem[i-1] + 64'($urandom_range(0, 4));
      model(0, 8, ps, fi, sm, nr);
      r0 = req_cnt;
      launch(0, 8, 64'h4000);
      repeat (3) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      cyc = -1;
      for (int c = 0; c < 200 && cyc < 0; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) cyc = c;
      end
      n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL b2b_timeout: done=%b expected 1", done); end
      n_checks++; if ({pass, sum} !== {ps, sm}) begin n_fail++; $display("FAIL b2b_result: pass=%b sum=%0d expected %b/%0d", pass, sum, ps, sm); end
      n_checks++; if (req_cnt - r0 !== nr) begin n_fail++; $display("FAIL b2b_reqs: got %0d expected %0d", req_cnt - r0, nr); end
      r1 = req_cnt;
      repeat (4) @(negedge clk);
      n_checks++; if ({done, busy} !== 2'b10 || req_cnt !== r1) begin n_fail++; $display("FAIL b2b_hold: done=%b busy=%b new_reqs=%0d expected 1/0/0", done, busy, req_cnt - r1); end
      // fresh check after done: outputs cleared on the accepting edge
      for (int i = 0; i < 3; i++) mem[i] = {$urandom, $urandom};
      model(3, 3, ps, fi, sm, nr);
      launch(3, 3, 64'h4000);
      @(posedge clk); #1;
      n_checks++; if ({done, busy, pass, fail_idx, sum} !== {1'b0, 1'b1, 1'b0, 8'd0, 64'd0}) begin n_fail++; $display("FAIL restart_clear: done=%b busy=%b pass=%b sum=%0d expected 0/1/0/0", done, busy, pass, sum); end
      wait_done(50, cyc);
      n_checks++; if ({pass, sum} !== {ps, sm}) begin n_fail++; $display("FAIL restart_result: pass=%b sum=%h expected %b/%h", pass, sum, ps, sm); end
   endtask

   task automatic test_reset_mid();
      int cyc, r0, nr, fi;
      bit ps;
      logic [63:0] sm;
      rand_lat = 1'b0;
      for (int i = 0; i < 10; i++) mem[i] = 64'(i * 3);
      r0 = req_cnt;
      launch(0, 10, 64'h5000);
      for (int c = 0; c < 100 && (req_cnt - r0) < 3; c++) begin
         @(negedge clk); #1;
      end
      n_checks++; if (rd_req !== 1'b1) begin n_fail++; $display("FAIL midrst_req: rd_req=%b expected 1 before reset", rd_req); end
      rst = 1'b0;
      #1;
      n_checks++; if ({busy, done, pass, rd_req, fail_idx, sum, rd_addr} !== '0) begin n_fail++; $display("FAIL midrst_outputs: busy=%b done=%b rd_req=%b sum=%0d expected all 0", busy, done, rd_req, sum); end
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model(0, 10, ps, fi, sm, nr);
      launch(0, 10, 64'h5000);
      wait_done(100, cyc);
      n_checks++; if (cyc !== 20) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 20", cyc); end
      n_checks++; if ({pass, fail_idx, sum} !== {ps, IW'(fi), sm}) begin n_fail++; $display("FAIL midrst_result: pass=%b fail_idx=%0d sum=%0d expected %b/%0d/%0d", pass, fail_idx, sum, ps, fi, sm); end
   endtask

   task automatic test_random();
      int cyc, r0, nr, fi, md, len, k;
      bit ps;
      logic [63:0] sm;
      longint v;
      rand_lat = 1'b1;
      for (int it = 0; it < 8; it++) begin
         md  = int'($urandom_range(0, 3));
         len = int'($urandom_range(1, 12));
         v   = longint'($urandom_range(0, 40)) - 20;
         for (int i = 0; i < len; i++) begin
            case (md)
               0: begin mem[i] = v; v = v + longint'($urandom_range(0, 3)); end
               1: begin mem[i] = v; v = v - longint'($urandom_range(0, 3)); end
               2: begin mem[i] = (i < 2) ? 64'd1 : mem[i-1] + mem[i-2]; end
               default: mem[i] = {$urandom, $urandom};
            endcase
         end
         if ($urandom_range(0, 1) == 1) begin
            k = int'($urandom_range(0, len - 1));
            mem[k] = (md == 1) ? mem[k] + 64'd7 : mem[k] - 64'd7;
         end
         model(md, len, ps, fi, sm, nr);
         r0 = req_cnt;
         launch(md, len, 64'(it) << 12);
         wait_done(200, cyc);
         n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL rand%0d_timeout: done=%b expected 1", it, done); end
         n_checks++; if (pass !== ps) begin n_fail++; $display("FAIL rand%0d_pass: mode %0d len %0d got %b expected %b", it, md, len, pass, ps); end
         n_checks++; if (fail_idx !== IW'(fi)) begin n_fail++; $display("FAIL rand%0d_fail_idx: got %0d expected %0d", it, fail_idx, fi); end
         n_checks++; if (sum !== sm) begin n_fail++; $display("FAIL rand%0d_sum: got %h expected %h", it, sum, sm); end
         n_checks++; if (req_cnt - r0 !== nr) begin n_fail++; $display("FAIL rand%0d_reqs: got %0d expected %0d", it, req_cnt - r0, nr); end
      end
   endtask

   task automatic test_sum_wrap();
      int cyc;
      int exp_sum;
      mem8[0] = 8'd200;
      mem8[1] = 8'd100;
      exp_sum = (200 + 100) % 256;
      @(negedge clk);
      mode8 = 2'd3; length8 = 4'd2; base8 = 16'h0020; start8 = 1'b1;
      cyc = -1;
      for (int c = 0; c < 50 && cyc < 0; c++) begin
         @(posedge clk); #1;
         if (done8 === 1'b1) cyc = c;
      end
      n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL wrap_timeout: done=%b expected 1", done8); end
      n_checks++; if (sum8 !== 8'(exp_sum)) begin n_fail++; $display("FAIL wrap_sum: got %0d expected %0d", sum8, exp_sum); end
      n_checks++; if (pass8 !== 1'b1) begin n_fail++; $display("FAIL wrap_pass: got %b expected 1", pass8); end
   endtask

   initial begin
      test_reset();
      test_ascending();
      test_descending();
      test_fibonacci();
      test_length_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_sum_wrap();
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_result_checker.md
Name: mem_result_checker

Overview:
- Synthesizable post-run result checker for the pipelined CPU system.
- On a rising edge of the CPU `halt` line it walks a region of data memory through a read handshake. It checks the region against a selectable property: ascending sort, descending sort, Fibonacci sequence, or checksum only.
- It reports pass/fail, the first failing index and a running sum.
- Replaces the hard-coded sort-only post-halt check with a parametrised hardware block usable in simulation, FPGA bring-up and synthesized netlists.

Parameters:
- DATA_W, 64, memory word width.
- ADDR_W, 64, byte-address width.
- IDX_W, 8, element-index and length width.
- WORD_BYTES, 8, address stride between consecutive elements.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  level input (tie to CPU halt); rising edge triggers one check.
- mode  input  2  0 ascending, 1 descending, 2 Fibonacci, 3 sum-only; sampled on the start edge.
- base_addr  input  ADDR_W  byte address of element 0; sampled on the start edge.
- length  input  IDX_W  element count; sampled on the start edge.
- rd_req  output  1  read request, one-cycle pulse.
- rd_addr  output  ADDR_W  read address, valid while rd_req is high.
- rd_valid  input  1  read data valid, 1 or more cycles after rd_req.
- rd_data  input  DATA_W  read data, sampled when rd_valid is high.
- busy  output  1  check in progress.
- done  output  1  result valid; level, held until the next start edge.
- pass  output  1  check result, meaningful while done is high.
- fail_idx  output  IDX_W  index of the first failing element; 0 when passing.
- sum  output  DATA_W  sum of elements read, modulo 2^DATA_W.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; start_q = 0.
- Start edge detect: edge = start & ~start_q, where start_q is a registered copy of start. Because start_q resets to 0, start held high across reset release produces one edge.
- States: IDLE, REQ, WAIT, DONE.
- IDLE or DONE, on edge:
  - latch mode, base_addr, length;
  - clear done, pass, fail_idx, sum and idx;
  - set busy;
  - go to REQ, or to DONE with pass=1 if length==0.
- REQ: assert rd_req=1 for exactly one cycle with rd_addr = base_addr + idx*WORD_BYTES (truncated to ADDR_W); go to WAIT. rd_req is issued the cycle after the edge.
- WAIT: hold until rd_valid. On the rd_valid cycle:
  - sum += rd_data;
  - evaluate element idx (rules below);
  - on failure: fail_idx=idx, pass=0, go to DONE immediately with no further reads;
  - otherwise: prev=rd_data, idx++; if idx==length go to DONE with pass=1, else go to REQ.
- Element rules (signed comparison on DATA_W):
  - mode 0: element idx>0 fails if data < prev; equal values pass.
  - mode 1: element idx>0 fails if data > prev.
  - mode 2: element compared to the expected value: exp0=1, exp1=1, exp_i = exp_{i-1} + exp_{i-2} mod 2^DATA_W. Fails on inequality.
  - mode 3: never fails.
  - Element 0 never fails in modes 0, 1 and 3.
- DONE: busy=0, done=1, outputs frozen until the next edge.
- Minimum latency per element is 2 cycles (REQ plus WAIT with rd_valid=1 the cycle after rd_req).
- Ignored inputs:
  - start edges while busy;
  - rd_valid outside WAIT;
  - a single rd_valid completes exactly one request.
- Reset asserted mid-check: immediate return to reset values; rd_req deasserts asynchronously; no partial result is reported.
- length = 2^IDX_W - 1 is the maximum; idx must not wrap.

Decomposition:
- Shared package `checker_pkg`: mode encodings (MODE_ASC, MODE_DESC, MODE_FIB, MODE_SUM) and FSM state encodings.
- One natural sub-module, `chk_element_eval`: combinational pass/fail from mode, idx, data, prev and the expected Fibonacci value. It is instantiated once.
- The Fibonacci generator registers (exp_prev1, exp_prev2) and the read FSM stay in the top.

Test Plan:
- Ascending pass: mode 0, length 10, memory {-3,0,0,2,5,7,7,9,11,20}, rd_valid 1 cycle after rd_req → done=1, pass=1, fail_idx=0, sum=58, 20 cycles from edge to done.
- Descending fail: mode 1, length 5, data {9,8,8,10,1} → pass=0, fail_idx=3, sum=35, exactly 4 rd_req pulses.
- Fibonacci with variable latency: mode 2, length 20, correct Fibonacci f(1..20), rd_valid delay randomised 1–5 cycles → pass=1, sum=17710. Corrupt element 6 to 14 → fail_idx=6.
- Edge and length corners:
  - length 0 → done one cycle after the edge, pass=1, no rd_req;
  - start held high with a second rise while busy → ignored;
  - a new edge after done → fresh check with cleared outputs.
- Reset mid-check: assert rst at the 3rd element → all outputs 0 asynchronously. Release and raise start → complete correct check.
- Sum wrap: mode 3, DATA_W=8 build, data {200,100} → sum=44, pass=1.
